// File: rtl/job_feeder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | job_feeder_pkg                                                       |
// | Shared widths, FSM state type and job record for job_feeder.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package job_feeder_pkg;

  localparam int c_X_W  = 8;
  localparam int c_ON_W = 2;
  localparam int c_S_W  = 3;
  localparam int c_Y_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACT = 2'd2,
    ST_RUN      = 2'd3
  } state_t;

  typedef struct packed {
    logic [c_X_W-1:0]  x;
    logic [c_ON_W-1:0] on;
  } job_t;

  localparam int c_JOB_W = $bits(job_t);

endpackage
`default_nettype wire

// File: rtl/job_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | job_fifo                                                             |
// | DEPTH-entry synchronous job queue with occupancy count.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module job_fifo
  import job_feeder_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int c_CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  job_t               push_data,
  input  logic               pop,
  output job_t               pop_data,
  output logic [c_CNT_W-1:0] count,
  output logic               full,
  output logic               empty
);

  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  job_t               r_mem [DEPTH];
  logic               w_push;
  logic               w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign pop_data = r_mem[r_rd_ptr];
  assign count    = r_count;
  assign full     = (r_count == c_CNT_W'(DEPTH));
  assign empty    = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/job_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | job_feeder                                                           |
// | Queues host jobs, issues them to one arithmetic unit and holds the   |
// | result behind a valid/ready handshake. Optional watchdog abort is    |
// | enabled with JOB_FEEDER_WATCHDOG_EN.                                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module job_feeder
  import job_feeder_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [c_X_W-1:0]  job_x,
  input  logic [c_ON_W-1:0] job_on,
  output logic [c_X_W-1:0]  x,
  output logic [c_ON_W-1:0] on,
  output logic              start,
  input  logic              active,
  input  logic [c_Y_W-1:0]  y,
  input  logic [c_S_W-1:0]  s,
  input  logic              b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [c_Y_W-1:0]  res_y,
  output logic [c_S_W-1:0]  res_s,
  output logic              res_b,
  output logic              res_err,
  output logic              busy
);

  localparam int c_CNT_W = $clog2(DEPTH + 1);

  state_t             r_state;
  state_t             w_state_next;
  job_t               w_push_job;
  job_t               w_head;
  logic [c_CNT_W-1:0] w_fifo_count;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_pop;
  logic               w_capture;
  logic               w_abort;
  logic               w_timeout;
  logic               w_res_blocked;

  logic [c_X_W-1:0]   r_x;
  logic [c_ON_W-1:0]  r_on;
  logic               r_res_valid;
  logic [c_Y_W-1:0]   r_res_y;
  logic [c_S_W-1:0]   r_res_s;
  logic               r_res_b;
  logic               r_res_err;

  assign w_push_job = {job_x, job_on};

  job_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (job_valid),
    .push_data (w_push_job),
    .pop       (w_pop),
    .pop_data  (w_head),
    .count     (w_fifo_count),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  // A result being drained this edge does not block the next issue.
  assign w_res_blocked = r_res_valid && !res_ready;

`ifdef JOB_FEEDER_WATCHDOG_EN
  logic [15:0] r_wdog;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog <= '0;
    end else if (r_state == ST_ISSUE) begin
      r_wdog <= '0;
    end else if ((r_state == ST_WAIT_ACT) || (r_state == ST_RUN)) begin
      r_wdog <= r_wdog + 16'd1;
    end
  end

  // Fires in the TIMEOUT-th cycle spent waiting or running.
  assign w_timeout = ((r_state == ST_WAIT_ACT) || (r_state == ST_RUN)) &&
                     (r_wdog == 16'(TIMEOUT - 1));
`else
  logic [15:0] w_unused_timeout;

  assign w_unused_timeout = 16'(TIMEOUT);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty && !w_res_blocked) begin
          w_pop        = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state_next = ST_WAIT_ACT;
      end
      ST_WAIT_ACT: begin
        if (w_timeout) begin
          w_abort      = 1'b1;
          w_state_next = ST_IDLE;
        end else if (active) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // A genuine completion outranks a coincident watchdog expiry.
        if (!active) begin
          w_capture    = 1'b1;
          w_state_next = ST_IDLE;
        end else if (w_timeout) begin
          w_abort      = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x         <= '0;
      r_on        <= '0;
      r_res_valid <= 1'b0;
      r_res_y     <= '0;
      r_res_s     <= '0;
      r_res_b     <= 1'b0;
      r_res_err   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_x  <= w_head.x;
        r_on <= w_head.on;
      end
      if (w_capture) begin
        r_res_valid <= 1'b1;
        r_res_y     <= y;
        r_res_s     <= s;
        r_res_b     <= b;
        r_res_err   <= 1'b0;
      end else if (w_abort) begin
        r_res_valid <= 1'b1;
        r_res_y     <= '0;
        r_res_s     <= '0;
        r_res_b     <= 1'b0;
        r_res_err   <= 1'b1;
      end else if (r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign job_ready = !w_fifo_full;
  assign x         = r_x;
  assign on        = r_on;
  assign start     = (r_state == ST_ISSUE);
  assign res_valid = r_res_valid;
  assign res_y     = r_res_y;
  assign res_s     = r_res_s;
  assign res_b     = r_res_b;
  assign res_err   = r_res_err;
  assign busy      = (r_state != ST_IDLE) || (w_fifo_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_job_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_job_feeder                                                        |
// | Directed bench for job_feeder with a transaction-level model and a   |
// | simple arithmetic-unit responder.                                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_job_feeder;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       job_valid = 1'b0;
  logic       job_ready;
  logic [7:0] job_x = '0;
  logic [1:0] job_on = '0;
  logic [7:0] x;
  logic [1:0] on;
  logic       start;
  logic       active = 1'b0;
  logic [7:0] y = '0;
  logic [2:0] s = '0;
  logic       b = 1'b0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_y;
  logic [2:0] res_s;
  logic       res_b;
  logic       res_err;
  logic       busy;

  int checks = 0;
  int failures = 0;

  job_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_x(job_x), .job_on(job_on), .x(x), .on(on), .start(start),
    .active(active), .y(y), .s(s), .b(b), .res_valid(res_valid),
    .res_ready(res_ready), .res_y(res_y), .res_s(res_s), .res_b(res_b),
    .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Unit responder: active for u_len cycles starting u_delay cycles after start.
  int         u_delay = 2;
  int         u_len = 5;
  bit         u_mode = 1'b0;
  bit         u_stall = 1'b0;
  logic [7:0] u_y = '0;
  logic [2:0] u_s = '0;
  logic       u_b = 1'b0;
  logic [7:0] u_x = '0;
  logic [1:0] u_on = '0;
  int         u_phase = 0;
  bit         u_run = 1'b0;

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      u_run = 1'b0; u_phase = 0; active = 1'b0;
    end else if (u_run) begin
      u_phase++;
      active = (u_phase >= u_delay) && (u_phase < u_delay + u_len);
      if (u_phase >= u_delay + u_len) begin
        u_run = 1'b0;
        if (u_mode) begin y = ~u_x; s = {1'b0, u_on}; b = u_x[0]; end
        else begin y = u_y; s = u_s; b = u_b; end
      end
    end else if (start && !u_stall) begin
      u_run = 1'b1; u_phase = 0; u_x = x; u_on = on;
      y = '0; s = '0; b = 1'b0;
    end
  end

  // Transaction-level model of the feeder.
  logic [9:0] m_q[$];
  logic [9:0] m_j;
  bit         m_inflight = 0, m_start = 0, m_after = 0, m_act = 0, m_pp2 = 0;
  int         m_wd = 0;
  logic [7:0] m_x = '0, m_ry = '0;
  logic [1:0] m_on = '0;
  logic [2:0] m_rs = '0;
  logic       m_rv = 0, m_rb = 0, m_re = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_inflight = 0; m_start = 0; m_after = 0; m_act = 0; m_pp2 = 0; m_wd = 0;
      m_x = '0; m_on = '0; m_rv = 0; m_ry = '0; m_rs = '0; m_rb = 0; m_re = 0;
    end else begin
      bit do_push, do_pop, fin, abt;
      int sz;
      sz = m_q.size();
      do_push = job_valid && (sz < DEPTH);
      fin = 0; abt = 0;
      if (m_inflight && m_after) begin
        if (m_act && !active) fin = 1;
`ifdef JOB_FEEDER_WATCHDOG_EN
        else if (m_wd == TIMEOUT - 1) abt = 1;
`endif
        else begin
          if (active) m_act = 1;
          m_wd++;
        end
      end
      do_pop = !m_inflight && (sz > 0) && (!m_rv || res_ready);
      m_pp2 = do_push && do_pop && (sz == 2);
      if (fin) begin m_rv = 1; m_ry = y; m_rs = s; m_rb = b; m_re = 0; end
      else if (abt) begin m_rv = 1; m_ry = '0; m_rs = '0; m_rb = 0; m_re = 1; end
      else if (m_rv && res_ready) m_rv = 0;
      if (fin || abt) begin m_inflight = 0; m_after = 0; m_act = 0; end
      if (m_start) begin m_start = 0; m_after = 1; m_wd = 0; end
      if (do_pop) begin
        m_j = m_q.pop_front();
        m_x = m_j[9:2]; m_on = m_j[1:0]; m_inflight = 1; m_start = 1;
      end
      if (do_push) m_q.push_back({job_x, job_on});
    end
  end

  always @(negedge clk) begin
    chk("job_ready", {31'd0, job_ready}, {31'd0, m_q.size() < DEPTH});
    chk("start", {31'd0, start}, {31'd0, m_start});
    chk("x", {24'd0, x}, {24'd0, m_x});
    chk("on", {30'd0, on}, {30'd0, m_on});
    chk("res_valid", {31'd0, res_valid}, {31'd0, m_rv});
    chk("res_y", {24'd0, res_y}, {24'd0, m_ry});
    chk("res_s", {29'd0, res_s}, {29'd0, m_rs});
    chk("res_b", {31'd0, res_b}, {31'd0, m_rb});
    chk("res_err", {31'd0, res_err}, {31'd0, m_re});
    chk("busy", {31'd0, busy}, {31'd0, m_inflight || (m_q.size() > 0)});
    chk("count", 32'(dut.w_fifo_count), 32'(m_q.size()));
    if (m_pp2) chk("pushpop_count2", 32'(dut.w_fifo_count), 32'd2);
  end

  // Event monitors, sampled mid-cycle.
  int         cyc = 0;
  int         start_cnt = 0, last_start = 0, rise_cnt = 0, last_rise = 0, last_fall = 0;
  logic       prev_rv = 0, prev_act = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (start) begin start_cnt++; last_start = cyc; end
    if (res_valid && !prev_rv) begin rise_cnt++; last_rise = cyc; end
    prev_rv = res_valid;
    if (prev_act && !active) last_fall = cyc;
    prev_act = active;
    if (res_valid && res_ready) got.push_back(res_y);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int t_acc = 0;

  task automatic push(input logic [7:0] xx, input logic [1:0] oo);
    int n = 0;
    job_valid = 1'b1; job_x = xx; job_on = oo;
    while (!job_ready && n < 200) begin tick(1); n++; end
    chk("push_accept_bound", {31'd0, job_ready}, 32'd1);
    tick(1);
    t_acc = cyc;
    job_valid = 1'b0;
  endtask

  task automatic wait_res(input string name, input int bound);
    int n = 0;
    while (!res_valid && n < bound) begin tick(1); n++; end
    chk(name, {31'd0, res_valid}, 32'd1);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while ((busy || res_valid) && n < bound) begin tick(1); n++; end
    chk(name, {30'd0, busy, res_valid}, 32'd0);
  endtask

  task automatic check_order(input string name);
    chk({name, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk(name, {24'd0, got[i]}, {24'd0, exp_q[i]});
  endtask

  int sc0 = 0, k = 0, rc = 0, r1 = 0;

  initial begin
    #2 rst = 1'b0;
    tick(2);
    chk("rst_job_ready", {31'd0, job_ready}, 32'd1);
    chk("rst_outputs", {job_x * 0, x, on, start, res_valid, res_err, busy}, 32'd0);
    @(negedge clk); rst = 1'b1;
    tick(1);

    // Single job through the unit.
    u_delay = 2; u_len = 5; u_mode = 0; u_y = 8'h3C; u_s = 3'd5; u_b = 1'b1;
    sc0 = start_cnt;
    push(8'h5A, 2'd2);
    wait_res("t1_res_wait", 50);
    tick(1);
    chk("t1_start_once", 32'(start_cnt - sc0), 32'd1);
    chk("t1_start_lat", 32'(last_start - t_acc), 32'd1);
    chk("t1_res_lat", 32'(last_rise - last_start), 32'd8);
    chk("t1_res_after_fall", 32'(last_rise - last_fall), 32'd1);
    chk("t1_res", {19'd0, res_err, res_b, res_s, res_y}, {19'd0, 1'b0, 1'b1, 3'd5, 8'h3C});
    chk("t1_xon", {22'd0, x, on}, {22'd0, 8'h5A, 2'd2});

    // Queue fills while the first result is held.
    u_mode = 1;
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i), 2'(i));
    chk("t2_full", {31'd0, job_ready}, 32'd0);
    job_valid = 1'b1; job_x = 8'h14; job_on = 2'd0;
    tick(5);
    chk("t2_held", {31'd0, job_ready}, 32'd0);
    chk("t2_no_start", 32'(start_cnt - sc0), 32'd1);
    got.delete();
    res_ready = 1'b1; k = cyc;
    tick(1);
    begin
      int n = 0;
      while (!job_ready && n < 10) begin tick(1); n++; end
    end
    tick(1);
    job_valid = 1'b0;
    chk("t2_bp_start", 32'(last_start - k), 32'd1);
    wait_idle("t2_idle", 200);
    tick(1);
    exp_q = '{8'h3C, 8'hEF, 8'hEE, 8'hED, 8'hEC, 8'hEB};
    check_order("t2_order");

    // Push and pop on the same edge with two entries queued.
    res_ready = 1'b0; got.delete();
    push(8'hA0, 2'd0); push(8'hA1, 2'd1); push(8'hA2, 2'd2);
    wait_res("t3_res_wait", 50);
    tick(1);
    chk("t3_count_pre", 32'(dut.w_fifo_count), 32'd2);
    res_ready = 1'b1; job_valid = 1'b1; job_x = 8'hA3; job_on = 2'd3;
    tick(1);
    job_valid = 1'b0;
    chk("t3_count_post", 32'(dut.w_fifo_count), 32'd2);
    for (int i = 4; i < 8; i++) push(8'hA0 + 8'(i), 2'(i));
    wait_idle("t3_idle", 300);
    tick(1);
    exp_q = '{8'h5F, 8'h5E, 8'h5D, 8'h5C, 8'h5B, 8'h5A, 8'h59, 8'h58};
    check_order("t3_order");

    // Reset in the middle of a run.
    u_len = 20;
    push(8'hB0, 2'd1); push(8'hB1, 2'd2);
    begin
      int n = 0;
      while (!active && n < 20) begin tick(1); n++; end
    end
    tick(2);
    @(negedge clk); #2; rst = 1'b0; #1;
    chk("t4_job_ready", {31'd0, job_ready}, 32'd1);
    chk("t4_outputs", {x, on, start, res_valid, res_y, res_s, res_b, res_err, busy}, 32'd0);
    rc = rise_cnt; sc0 = start_cnt;
    @(posedge clk); #1;
    tick(2);
    rst = 1'b1;
    tick(30);
    chk("t4_no_result", 32'(rise_cnt - rc), 32'd0);
    chk("t4_no_start", 32'(start_cnt - sc0), 32'd0);
    u_len = 5;

`ifdef JOB_FEEDER_WATCHDOG_EN
    // Unit never responds; both jobs are aborted by the watchdog.
    u_stall = 1'b1; res_ready = 1'b1;
    push(8'hC0, 2'd0); push(8'hC1, 2'd1);
    wait_res("t5_res_wait", 40);
    chk("t5_abort_res", {20'd0, res_err, res_b, res_s, res_y}, {20'd0, 1'b1, 1'b0, 3'd0, 8'h00});
    tick(1);
    chk("t5_wd_lat", 32'(last_rise - last_start), 32'd11);
    r1 = last_rise;
    wait_idle("t5_idle", 100);
    chk("t5_next_issue", 32'(last_start - r1), 32'd1);
    u_stall = 1'b0;
`endif

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
